adder_share_arbiter: RTL
========================

# adder_share_arbiter

Round-robin arbiter that time-shares one combinational 32-bit `Adder` instance among up to four requesters in the CPU datapath, e.g. PC+4, branch target and address generation. Each requester presents two operands under a valid/ready handshake. The block steers the winning pair onto the shared adder and registers the sum, the requester ID and a signed-overflow flag into a single-entry response register. The response register drains under its own valid/ready handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..4.
- `ID_W`, default 2: width of requester ID; must satisfy 2^ID_W >= NUM_REQ.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester operand-pair valid.
- `req_src1_i`  in  NUM_REQ*32  packed operand 1; requester k occupies bits [32k+31:32k].
- `req_src2_i`  in  NUM_REQ*32  packed operand 2, same packing.
- `req_ready_o`  out  NUM_REQ  one-hot-or-zero grant; the transfer for requester k occurs when valid[k] and ready[k] are both high.
- `add_src1_o`  out  32  to shared Adder `src1_i`.
- `add_src2_o`  out  32  to shared Adder `src2_i`.
- `add_sum_i`  in  32  from shared Adder `sum_o`; combinational, same cycle.
- `rsp_valid_o`  out  1  response register holds a result.
- `rsp_ready_i`  in  1  consumer accepts the response.
- `rsp_sum_o`  out  32  registered sum.
- `rsp_id_o`  out  ID_W  index of the requester that produced `rsp_sum_o`.
- `rsp_ovf_o`  out  1  signed overflow of the registered sum.

## Operation
- Response register state: EMPTY (`rsp_valid_o`=0) or FULL (`rsp_valid_o`=1).
- The arbiter may grant when the register is EMPTY, or when it is FULL and `rsp_ready_i`=1 (pass-through drain and refill in the same cycle).
- When the arbiter may grant, grant goes to the first requester with valid=1, scanning from `rr_ptr` upward modulo NUM_REQ. No valid requester means no grant.
- At most one `req_ready_o` bit is high. It is high only for the granted requester. `req_ready_o` never rises for a requester whose valid is 0.
- Adder operands:
  - `add_src1_o`/`add_src2_o` carry the granted requester's operands.
  - With no grant they carry requester `rr_ptr`'s operands. Those values are don't-care, but the mux must never produce X.
- On a grant, at the next edge:
  - `rsp_sum_o` <= `add_sum_i`; `rsp_id_o` <= granted index; `rsp_valid_o` <= 1.
  - `rsp_ovf_o` <= (src1[31]==src2[31]) && (sum[31]!=src1[31]).
  - `rr_ptr` <= (granted index + 1) mod NUM_REQ.
- Arithmetic: two's complement, wrap modulo 2^32. Overflow is flagged only, never saturated.
- FULL and `rsp_ready_i`=1 with no grant: next state EMPTY.
- FULL and `rsp_ready_i`=0: hold all response outputs stable; all `req_ready_o`=0; `rr_ptr` unchanged.
- A requester holds its valid and operands stable until its transfer completes. A requester whose valid stays high is granted within NUM_REQ grant opportunities (no starvation).
- Reset (`rst_i`=0 at an edge), including mid-operation:
  - `rsp_valid_o`=0, `rsp_sum_o`=0, `rsp_id_o`=0, `rsp_ovf_o`=0, `rr_ptr`=0.
  - Any held, unconsumed response is discarded.
  - `req_ready_o` is forced to 0 for the whole cycle in which `rst_i`=0.

## Timing
- Accept-to-response latency is 1 cycle: a grant in cycle N gives `rsp_valid_o`=1 in cycle N+1.
- Sustained throughput is 1 result per cycle when `rsp_ready_i` is held high.
- Combinational paths:
  - `req_valid_i` -> `req_ready_o`.
  - `rsp_ready_i` -> `req_ready_o`.
  - `req_src*_i` -> `add_src*_o`.
  - `add_sum_i` is sampled at the edge only.
- Adder path budget: operand mux + Adder + overflow logic fits in one cycle.
- Response outputs change only at clock edges.

## Test plan
- Reset: hold `rst_i`=0 for 2 cycles with all `req_valid_i`=1.
  - During reset: `req_ready_o`=0.
  - After release: `rsp_valid_o`=0, `rsp_sum_o`=0, `rsp_id_o`=0, `rsp_ovf_o`=0.
  - First grant goes to requester 0.
- Single request: requester 2 sends 0x00000004 + 0x00400000 with `rsp_ready_i`=1.
  - `req_ready_o`=4'b0100 in the same cycle.
  - Next cycle: `rsp_valid_o`=1, `rsp_sum_o`=0x00400004, `rsp_id_o`=2, `rsp_ovf_o`=0.
- Round-robin fairness: all 4 valid continuously, `rsp_ready_i`=1.
  - Grant order is 0,1,2,3,0,1.
  - Exactly one response per cycle, with IDs in the same order.
- Backpressure: response FULL, `rsp_ready_i`=0 for 3 cycles.
  - `req_ready_o`=0 throughout; `rsp_*` stable.
  - On `rsp_ready_i`=1, the next requester is granted in that same cycle.
- Overflow/wrap:
  - 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, `rsp_ovf_o`=1.
  - 0xFFFFFFFF + 0x00000001 -> sum 0x00000000, `rsp_ovf_o`=0.
  - 0x80000000 + 0x80000000 -> sum 0x00000000, `rsp_ovf_o`=1.
- Reset mid-operation: assert `rst_i`=0 while FULL with `rr_ptr`=3.
  - Response is dropped; `rsp_valid_o`=0.
  - After release, with requesters 0 and 3 valid, requester 0 wins.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Bundle of the adder_share_arbiter request, shared-adder and response signals.
//   req_valid_i / req_ready_o : per-requester operand-pair handshake
//   req_src1_i / req_src2_i   : packed operands, requester k at bits [32k+31:32k]
//   add_src1_o / add_src2_o   : operands steered onto the shared combinational adder
//   add_sum_i                 : sum returned by the shared adder, same cycle
//   rsp_*                     : single-entry response register and its handshake
// The slave modport is the arbiter side; master is the requester/adder/consumer side.
interface adder_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*32-1:0] req_src1_i;
  logic [NUM_REQ*32-1:0] req_src2_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [31:0]           add_src1_o;
  logic [31:0]           add_src2_o;
  logic [31:0]           add_sum_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_sum_o;
  logic [ID_W-1:0]       rsp_id_o;
  logic                  rsp_ovf_o;

  modport slave (
    input  req_valid_i, req_src1_i, req_src2_i, add_sum_i, rsp_ready_i,
    output req_ready_o, add_src1_o, add_src2_o, rsp_valid_o, rsp_sum_o, rsp_id_o, rsp_ovf_o
  );

  modport master (
    output req_valid_i, req_src1_i, req_src2_i, add_sum_i, rsp_ready_i,
    input  req_ready_o, add_src1_o, add_src2_o, rsp_valid_o, rsp_sum_o, rsp_id_o, rsp_ovf_o
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one combinational 32-bit adder among NUM_REQ requesters.
// The winning operand pair is steered onto the adder; the sum, winner ID and signed-overflow
// flag are captured in a single-entry response register that drains by valid/ready.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-low reset
//   bus   : adder_share_arbiter_if slave modport (requests, adder link, response)
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  adder_share_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || (1 << ID_W) < NUM_REQ) begin : g_param_check
    $error("adder_share_arbiter: illegal NUM_REQ/ID_W");
  end

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q;
  logic [31:0]     rsp_sum_q;
  logic [ID_W-1:0] rsp_id_q;
  logic            rsp_ovf_q;

  logic            can_grant;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic            grant;
  logic            ovf;

  // Register may accept when empty, or when full and draining this cycle.
  assign can_grant = ~rsp_valid_q | bus.rsp_ready_i;

  // Scan from rr_ptr upward modulo NUM_REQ; gnt_idx defaults to rr_ptr so the operand
  // mux always selects an in-range requester even with no grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned cand;
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && bus.req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  // Reset forces the grant low for the whole cycle in which rst_i is asserted.
  assign grant = rst_i & can_grant & gnt_found;

  always_comb begin
    bus.req_ready_o = '0;
    if (grant) bus.req_ready_o[gnt_idx] = 1'b1;
  end

  assign bus.add_src1_o = bus.req_src1_i[32*int'(gnt_idx) +: 32];
  assign bus.add_src2_o = bus.req_src2_i[32*int'(gnt_idx) +: 32];

  // Signed overflow: operands agree in sign and the sum disagrees.
  assign ovf = (bus.add_src1_o[31] == bus.add_src2_o[31]) &&
               (bus.add_sum_i[31] != bus.add_src1_o[31]);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      if (gnt_idx == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        rsp_valid_q <= 1'b1;
        rsp_sum_q   <= bus.add_sum_i;
        rsp_id_q    <= gnt_idx;
        rsp_ovf_q   <= ovf;
      end else if (bus.rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_sum_o   = rsp_sum_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_ovf_o   = rsp_ovf_q;

endmodule
